// File: rtl/addsub_arb_pkg.sv
// addsub_arb_pkg: shared types and constants for the add/sub arbiter slice.
//   state_e        - sequencer FSM states (idle, execute, respond)
//   OP_ADD/OP_SUB  - opcode encodings for the sub inputs
package addsub_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_unit.sv
// addsub_unit: purely combinational signed add/subtract of two W-bit operands.
//   a, b    in  W : two's complement operands
//   sub     in  1 : OP_ADD computes a+b, OP_SUB computes a-b
//   result  out W : low W bits of the result (saturated when ADDSUB_SAT_EN is defined)
//   ovf     out 1 : signed overflow
// Build option: ADDSUB_SAT_EN clamps the result to the signed range on overflow.
module addsub_unit
    import addsub_arb_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] result,
    output logic         ovf
);

    logic [W:0] a_ext;
    logic [W:0] b_ext;
    logic [W:0] sum;

    always_comb begin
        a_ext = {a[W-1], a};
        b_ext = {b[W-1], b};
        sum   = (sub == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        // The W+1 bit sum holds the true sign in its MSB; a mismatch with bit W-1 is exactly
        // the case where equal-sign adds (or unequal-sign subs) flip away from a's sign.
        ovf   = sum[W] ^ sum[W-1];
`ifdef ADDSUB_SAT_EN
        if (ovf) begin
            // sum[W] is the sign of the unbounded result: 0 means positive overflow.
            result = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            result = sum[W-1:0];
        end
`else
        result = sum[W-1:0];
`endif
    end

endmodule

// File: rtl/addsub_arb.sv
// addsub_arb: round-robin arbiter and sequencer in front of a single addsub_unit.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester command handshake (2 bits each)
//   a0,b0,sub0 / a1,b1,sub1 : requester commands
//   rsp_valid/rsp_ready   : per-requester response handshake (2 bits each)
//   rsp_data, rsp_ovf     : registered result and signed-overflow flag, shared by both ports
//   busy                  : high whenever the FSM is not idle
// Build option: ADDSUB_SAT_EN (inside addsub_unit) selects saturating results.
module addsub_arb
    import addsub_arb_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         sub0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         sub1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_ovf,
    output logic         busy
);

    state_e state_q, state_d;

    logic         ptr_q;
    logic         w_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         sub_q;
    logic [W-1:0] data_q;
    logic         ovf_q;

    logic         any_req;
    logic         win;
    logic         accept;
    logic [W-1:0] unit_result;
    logic         unit_ovf;

    // Winner: pointer breaks ties, a lone request wins regardless of the pointer.
    always_comb begin
        any_req = |req_valid;
        if (req_valid == 2'b11) begin
            win = ptr_q;
        end else begin
            win = req_valid[1];
        end
        accept = (state_q == StIdle) && any_req;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (any_req) state_d = StExec;
            StExec: state_d = StResp;
            StResp: if (rsp_ready[w_q]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        // Held low while rst is asserted so the handshake cannot fire during reset.
        if (accept && !rst) begin
            req_ready[win] = 1'b1;
        end
        if (state_q == StResp) begin
            rsp_valid[w_q] = 1'b1;
        end
        busy = (state_q != StIdle);
    end

    // Command latch and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
            w_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= OP_ADD;
        end else if (accept) begin
            ptr_q <= ~win;
            w_q   <= win;
            a_q   <= win ? a1 : a0;
            b_q   <= win ? b1 : b0;
            sub_q <= win ? sub1 : sub0;
        end
    end

    addsub_unit #(
        .W (W)
    ) u_addsub_unit (
        .a      (a_q),
        .b      (b_q),
        .sub    (sub_q),
        .result (unit_result),
        .ovf    (unit_ovf)
    );

    // Result registers, loaded once in EXEC and held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else if (state_q == StExec) begin
            data_q <= unit_result;
            ovf_q  <= unit_ovf;
        end
    end

    assign rsp_data = data_q;
    assign rsp_ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_arb.sv
// tb_addsub_arb: directed self-checking bench for addsub_arb with W=8.
module tb_addsub_arb;

    localparam int unsigned W = 8;

`ifdef ADDSUB_SAT_EN
    localparam logic [7:0] EXP_POS_OVF = 8'h7f;
    localparam logic [7:0] EXP_NEG_OVF = 8'h80;
`else
    localparam logic [7:0] EXP_POS_OVF = 8'h80;
    localparam logic [7:0] EXP_NEG_OVF = 8'h7f;
`endif

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] a0, b0, a1, b1;
    logic         sub0, sub1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_ovf;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    addsub_arb #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .sub0      (sub0),
        .a1        (a1),
        .b1        (b1),
        .sub1      (sub1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-requester transaction with rsp_ready raised as soon as the response appears.
    task automatic do_op(input int port, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] exp_d, input logic exp_o);
        logic [1:0] m;
        m = (port == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        if (port == 1) begin
            a1 = a; b1 = b; sub1 = sub;
        end else begin
            a0 = a; b0 = b; sub0 = sub;
        end
        req_valid = m;
        rsp_ready = 2'b00;
        #1 chk("op_req_ready", req_ready, m);
        @(negedge clk);
        req_valid = 2'b00;
        chk("op_exec_req_ready", req_ready, 2'b00);
        chk("op_exec_rsp_valid", rsp_valid, 2'b00);
        chk("op_exec_busy", busy, 1'b1);
        @(negedge clk);
        chk("op_rsp_valid", rsp_valid, m);
        chk("op_rsp_data", rsp_data, exp_d);
        chk("op_rsp_ovf", rsp_ovf, exp_o);
        chk("op_rsp_busy", busy, 1'b1);
        rsp_ready = m;
        @(negedge clk);
        chk("op_done_rsp_valid", rsp_valid, 2'b00);
        chk("op_done_busy", busy, 1'b0);
        rsp_ready = 2'b00;
    endtask

    logic [1:0] exp_rr [7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    logic [1:0] exp_rv [7] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        a0 = '0; b0 = '0; sub0 = 1'b0;
        a1 = '0; b1 = '0; sub1 = 1'b0;

        // Reset state
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_ovf", rsp_ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Arithmetic vectors
        do_op(0, 8'd100, 8'd27, 1'b0, 8'h7f, 1'b0);
        do_op(0, 8'd100, 8'd28, 1'b0, EXP_POS_OVF, 1'b1);
        do_op(1, 8'h80, 8'h01, 1'b1, EXP_NEG_OVF, 1'b1);
        do_op(1, 8'hfb, 8'hfb, 1'b1, 8'h00, 1'b0);
        do_op(0, 8'hf6, 8'h03, 1'b0, 8'hf9, 1'b0);

        // Both requesters held valid right after reset: 0, 1, 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0 = 8'd1; b0 = 8'd2; sub0 = 1'b0;
        a1 = 8'd10; b1 = 8'd3; sub1 = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("rr_seq_req_ready", req_ready, exp_rr[i]);
            chk("rr_seq_rsp_valid", rsp_valid, exp_rv[i]);
            chk("rr_not_both", (req_ready != 2'b11), 1'b1);
            if (i == 2) chk("rr_data_0", rsp_data, 8'd3);
            if (i == 5) chk("rr_data_1", rsp_data, 8'd7);
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("rr_third_rsp_valid", rsp_valid, 2'b01);
        chk("rr_third_data", rsp_data, 8'd3);
        @(negedge clk);
        chk("rr_drain_busy", busy, 1'b0);
        rsp_ready = 2'b00;

        // Response stall for 5 cycles; requester 1 waits, its rsp_ready is ignored
        a0 = 8'd5; b0 = 8'd3; sub0 = 1'b0;
        req_valid = 2'b01;
        #1 chk("stall_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b10;
        chk("stall_exec_req_ready", req_ready, 2'b00);
        @(negedge clk);
        rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_rsp_valid", rsp_valid, 2'b01);
            chk("stall_rsp_data", rsp_data, 8'd8);
            chk("stall_req_ready", req_ready, 2'b00);
            chk("stall_busy", busy, 1'b1);
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        #1 chk("stall_last_rsp_valid", rsp_valid, 2'b01);
        @(negedge clk);
        chk("stall_done_rsp_valid", rsp_valid, 2'b00);
        chk("stall_done_busy", busy, 1'b0);
        chk("stall_waiting_grant", req_ready, 2'b10);
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        // Reset during EXEC aborts the operation and clears the pointer
        @(negedge clk);
        a0 = 8'd50; b0 = 8'd20; sub0 = 1'b0;
        req_valid = 2'b01;
        #1 chk("abort_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        chk("abort_in_exec", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_rsp_valid", rsp_valid, 2'b00);
        chk("abort_rsp_data", rsp_data, 8'h00);
        chk("abort_rsp_ovf", rsp_ovf, 1'b0);
        chk("abort_req_ready", req_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 2'b00);
            chk("abort_idle", busy, 1'b0);
        end
        req_valid = 2'b11;
        #1 chk("abort_next_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("abort_next_rsp_valid", rsp_valid, 2'b01);
        chk("abort_next_data", rsp_data, 8'd70);
        @(negedge clk);
        chk("abort_next_done", busy, 1'b0);
        rsp_ready = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_arb.md
# addsub_arb

Two-port arbiter and sequencer for a shared signed add/subtract datapath. Two independent requesters each present an operand pair and an add/sub opcode over valid/ready; the block grants one at a time round-robin, runs the operation through a single registered signed adder, and returns the result and a signed-overflow flag on a per-requester response handshake. It sits between the tile's input decode logic and the single `addsub_unit` instance so that the adder is never driven by two sources.

## Interface
- `W`, default 8: operand and result width in bits, two's complement; legal range 2..32.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous active-high reset.
- `req_valid`  in  2: bit i high means requester i presents a command.
- `req_ready`  out  2: bit i high means requester i's command is accepted this cycle.
- `a0`, `b0`  in  W each: requester 0 operands, signed.
- `sub0`  in  1: requester 0 opcode; 0 computes a+b, 1 computes a−b.
- `a1`, `b1`, `sub1`  in  W, W, 1: requester 1 command, same encoding.
- `rsp_valid`  out  2: bit i high means the result for requester i is presented.
- `rsp_ready`  in  2: bit i high means requester i consumes the result.
- `rsp_data`  out  W: result, shared by both response channels.
- `rsp_ovf`  out  1: signed overflow of the returned operation.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req_valid` bit is high, pick the winner `w`, assert `req_ready[w]` combinationally in the same cycle, latch `a_w`, `b_w`, `sub_w` and `w` at the clock edge, then go to EXEC. Otherwise stay in IDLE.
- Arbitration uses a 1-bit priority pointer `ptr` with reset value 0.
  - If both requests are valid, requester `ptr` wins.
  - If only one is valid, that one wins regardless of `ptr`.
  - After every grant, `ptr` becomes the complement of `w`.
- EXEC: compute through `addsub_unit` and register `rsp_data` and `rsp_ovf`, then go to RESP.
- RESP: hold `rsp_valid[w]` high with `rsp_data` and `rsp_ovf` stable. When `rsp_ready[w]` is high, complete the handshake and go to IDLE. `rsp_ready` of the non-granted port is ignored.
- `req_ready` is 0 in EXEC and RESP. Requests that arrive meanwhile wait, and command inputs are not sampled.
- Arithmetic:
  - Compute in W+1 bits after sign extension.
  - Overflow is set when both operand signs are equal for add, or differ for sub, and the result sign differs from a's sign.
  - `rsp_data` is the low W bits, i.e. wrap-around.
- Reset values: state IDLE, `ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_ovf`=0, `busy`=0.
- Reset mid-operation, in any state, aborts the operation. The accepted command is lost and no response is issued.

## Timing
- Accept at edge N, i.e. the cycle with `req_ready[w]`=1. `rsp_valid[w]` rises in cycle N+2.
- Minimum 3 cycles per operation: accept, exec, response with `rsp_ready` already high.
- Responses can stall indefinitely. While stalled, `busy` stays high and no grant is issued.
- `req_ready` depends combinationally on `req_valid`, state and `ptr`. There is no combinational path from `rsp_ready` to any output other than through the state register.

## Configuration
- `ADDSUB_SAT_EN` defined: on overflow, `rsp_data` saturates to 2^(W−1)−1 for positive overflow and −2^(W−1) for negative overflow. `rsp_ovf` is still reported.
- `ADDSUB_SAT_EN` undefined: wrap-around as above. The saturation logic is absent.

## Structure
- Package `addsub_arb_pkg` holds:
  - the FSM state enum (IDLE, EXEC, RESP);
  - the opcode constants `OP_ADD`=0 and `OP_SUB`=1.
- Sub-module `addsub_unit`:
  - purely combinational, parameterised by `W`;
  - inputs a, b, sub; outputs result and ovf;
  - contains the `ADDSUB_SAT_EN` logic.
- `addsub_arb` contains the FSM, the `ptr` register, the operand latches and the output registers.

## Test plan
All cases use W=8.
- Requester 0 sends 100+27 -> `rsp_valid[0]` in cycle N+2, `rsp_data`=127, `rsp_ovf`=0, `busy` high through the response.
- Requester 0 sends 100+28 -> `rsp_ovf`=1. `rsp_data`=−128 (0x80) when wrapping, 127 with `ADDSUB_SAT_EN`.
- Requester 1 sends −128−1 -> `rsp_ovf`=1. `rsp_data`=127 when wrapping, −128 with `ADDSUB_SAT_EN`. Requester 1 sends −5−(−5) -> 0, `rsp_ovf`=0.
- Both valid and held after reset -> requester 0 is granted first, then requester 1, then requester 0; `req_ready` alternates and never has both bits high.
- `rsp_ready` held low for 5 cycles in RESP -> `rsp_valid` and `rsp_data` stable, `req_ready`=0 throughout; the response completes on the cycle `rsp_ready` rises.
- `rst` asserted during EXEC -> all outputs 0 immediately, no `rsp_valid` pulse, and the next request after release is granted to requester 0.
